// File: rtl/mux_pkg.sv
// mux_pkg: mode constants and the rotate-and-find-first grant shared by the
// registered N:1 multiplexer and its arbiter.
package mux_pkg;
   localparam int MUX_MODE_RR    = 0;
   localparam int MUX_MODE_FIXED = 1;
   localparam int MUX_MAX_N      = 16;

   // One-hot grant of the first set request at or after start, wrapping at n.
   function automatic logic [MUX_MAX_N-1:0] rr_grant(
      input logic [MUX_MAX_N-1:0] req,
      input int                   n,
      input int                   start
   );
      logic [MUX_MAX_N-1:0] g;
      int                   idx;
      bit                   found;
      g     = '0;
      found = 1'b0;
      for (int k = 0; k < MUX_MAX_N; k++) begin
         idx = start + k;
         if (idx >= n) idx -= n;
         if (k < n && !found && req[idx]) begin
            g[idx] = 1'b1;
            found  = 1'b1;
         end
      end
      return g;
   endfunction
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: one-hot grant over req, round-robin from ptr or fixed lowest-index;
// ptr moves past the winner when advance is high.
module rr_arbiter
   import mux_pkg::*;
#(
   parameter int N = 4,
   localparam int SELW = $clog2(N)
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [N-1:0]    req,
   input  logic            advance,
   input  logic            mode,
   output logic [N-1:0]    gnt,
   output logic [SELW-1:0] gnt_idx
);
   logic [SELW-1:0]      ptr;
   logic [MUX_MAX_N-1:0] g16;

   assign g16 = rr_grant(MUX_MAX_N'(req), N, mode ? 0 : int'(ptr));
   assign gnt = g16[N-1:0];

   always_comb begin
      gnt_idx = '0;
      for (int i = 0; i < N; i++)
         if (gnt[i]) gnt_idx = SELW'(i);
   end

   // Explicit wrap keeps ptr in range when N is not a power of two.
   always_ff @(posedge clk or posedge rst)
      if (rst) ptr <= '0;
      else if (advance) ptr <= (gnt_idx == SELW'(N-1)) ? '0 : gnt_idx + SELW'(1);
endmodule

// File: rtl/muxn_rr_reg.sv
// muxn_rr_reg: arbitrated N:1 multiplexer with valid/ready on every channel and a
// one-entry output register that reloads on the same cycle it is popped.
module muxn_rr_reg
   import mux_pkg::*;
#(
   parameter int N     = 4,
   parameter int WIDTH = 2,
   parameter int MODE  = MUX_MODE_RR,
   localparam int SELW = $clog2(N)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [N-1:0]     in_valid,
   input  logic [N*WIDTH-1:0] in_data,
   output logic [N-1:0]     in_ready,
   output logic             out_valid,
   output logic [WIDTH-1:0] out_data,
   output logic [SELW-1:0]  out_sel,
   input  logic             out_ready
);
   logic [N-1:0]     gnt;
   logic [SELW-1:0]  gnt_idx;
   logic [WIDTH-1:0] sel_data;
   logic             load;
   logic             any_req;

   assign load     = ~out_valid | out_ready;
   assign any_req  = |in_valid;
   assign in_ready = (load & ~rst) ? gnt : '0;

   rr_arbiter #(.N(N)) u_arb (
      .clk     (clk),
      .rst     (rst),
      .req     (in_valid),
      .advance (load & any_req & (MODE == MUX_MODE_RR)),
      .mode    (MODE == MUX_MODE_FIXED),
      .gnt     (gnt),
      .gnt_idx (gnt_idx)
   );

   always_comb begin
      sel_data = '0;
      for (int i = 0; i < N; i++)
         sel_data |= in_data[i*WIDTH +: WIDTH] & {WIDTH{gnt[i]}};
   end

   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         out_sel   <= '0;
      end else if (load) begin
         out_valid <= any_req;
         if (any_req) begin
            out_data <= sel_data;
            out_sel  <= gnt_idx;
         end
      end
endmodule

// File: tb/tb_muxn_rr_reg.sv
// tb_muxn_rr_reg: directed checks of a round-robin and a fixed-priority instance
// sharing one stimulus stream (N=4, WIDTH=2, channel i drives data i).
module tb_muxn_rr_reg;
   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [3:0] in_valid = 4'b1111;
   logic [7:0] in_data = 8'b11_10_01_00;
   logic       out_ready = 1'b1;
   logic [3:0] in_ready, in_ready_f;
   logic       out_valid, out_valid_f;
   logic [1:0] out_data, out_data_f, out_sel, out_sel_f;
   int         checks = 0;
   int         failures = 0;

   always #5 clk = ~clk;

   muxn_rr_reg #(.N(4), .WIDTH(2), .MODE(0)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
      .in_ready(in_ready), .out_valid(out_valid), .out_data(out_data),
      .out_sel(out_sel), .out_ready(out_ready)
   );

   muxn_rr_reg #(.N(4), .WIDTH(2), .MODE(1)) dut_f (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
      .in_ready(in_ready_f), .out_valid(out_valid_f), .out_data(out_data_f),
      .out_sel(out_sel_f), .out_ready(out_ready)
   );

   task automatic chk(input string tag, input int obs, input int exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      tick();
      chk("rst_valid", int'(out_valid), 0);
      chk("rst_data", int'(out_data), 0);
      chk("rst_sel", int'(out_sel), 0);
      chk("rst_ready", int'(in_ready), 4'b0000);
      chk("rst_valid_f", int'(out_valid_f), 0);
      rst = 1'b0;
      #1;
      chk("post_rst_ready", int'(in_ready), 4'b0001);
      for (int k = 0; k < 8; k++) begin
         tick();
         chk("sweep_sel", int'(out_sel), k % 4);
         chk("sweep_data", int'(out_data), k % 4);
         chk("sweep_valid", int'(out_valid), 1);
      end
      in_valid = 4'b1010;
      #1;
      chk("sparse_ready", int'(in_ready), 4'b0010);
      tick();
      chk("sparse_1", int'(out_sel), 1);
      tick();
      chk("sparse_3", int'(out_sel), 3);
      tick();
      chk("sparse_wrap_1", int'(out_sel), 1);
      in_valid = 4'b1111;
      tick();
      chk("bp_load_data", int'(out_data), 2'b10);
      out_ready = 1'b0;
      #1;
      chk("bp_ready", int'(in_ready), 4'b0000);
      for (int k = 0; k < 3; k++) begin
         tick();
         chk("bp_hold_data", int'(out_data), 2'b10);
         chk("bp_hold_valid", int'(out_valid), 1);
         chk("bp_hold_ready", int'(in_ready), 4'b0000);
      end
      out_ready = 1'b1;
      #1;
      chk("bp_release_ready", int'(in_ready), 4'b1000);
      tick();
      chk("bp_release_sel", int'(out_sel), 3);
      in_valid = 4'b1110;
      #1;
      chk("fp_ready", int'(in_ready_f), 4'b0010);
      for (int k = 0; k < 3; k++) begin
         tick();
         chk("fp_sel", int'(out_sel_f), 1);
         chk("fp_data", int'(out_data_f), 1);
         chk("fp_valid", int'(out_valid_f), 1);
      end
      in_valid = 4'b0100;
      tick();
      chk("drain_load_sel", int'(out_sel), 2);
      chk("drain_load_valid", int'(out_valid), 1);
      in_valid = 4'b0000;
      tick();
      chk("drain_valid", int'(out_valid), 0);
      chk("drain_hold_sel", int'(out_sel), 2);
      chk("drain_hold_data", int'(out_data), 2'b10);
      in_valid = 4'b0100;
      tick();
      chk("refill_valid", int'(out_valid), 1);
      out_ready = 1'b0;
      in_valid = 4'b0000;
      #2;
      rst = 1'b1;
      #1;
      chk("async_rst_valid", int'(out_valid), 0);
      chk("async_rst_data", int'(out_data), 0);
      chk("async_rst_sel", int'(out_sel), 0);
      tick();
      rst = 1'b0;
      out_ready = 1'b1;
      in_valid = 4'b1111;
      #1;
      chk("ptr_reset_ready", int'(in_ready), 4'b0001);
      tick();
      chk("ptr_reset_sel", int'(out_sel), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/muxn_rr_reg.md
# muxn_rr_reg

Parametrised, registered N:1 multiplexer with valid/ready handshake on every channel and built-in arbitration. It replaces the plain 4:1 combinational select: instead of an external `sel`, it chooses among requesting channels by round-robin or fixed priority. Each winning word is captured in a one-entry output register. It sits between several producers of equal-width payloads and one shared consumer, for example a shared bus or a FIFO write port.

## Interface
Parameters:
- `N`, 4: number of input channels, 2..16.
- `WIDTH`, 2: payload width per channel, ≥1.
- `MODE`, 0: 0 = round-robin, 1 = fixed priority (lowest index wins).
- `SELW`, `$clog2(N)`: derived localparam, not overridable.

Ports:
- `clk` input 1: single clock, rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `in_valid` input N: per-channel request.
- `in_data` input N*WIDTH: channel i occupies bits `[i*WIDTH +: WIDTH]`.
- `in_ready` output N: one-hot or zero; channel i's word is taken when `in_valid[i] & in_ready[i]`.
- `out_valid` output 1: output register holds a word.
- `out_data` output WIDTH: registered payload.
- `out_sel` output SELW: index of the channel that supplied `out_data`.
- `out_ready` input 1: consumer accepts when `out_valid & out_ready`.

## Operation
- Output register state: EMPTY (`out_valid`=0) or FULL (`out_valid`=1).
- `load = ~out_valid | out_ready`: the register can take a new word this cycle.
- Grant:
  - Combinational one-hot `gnt` over `in_valid`.
  - In round-robin mode, search starts at pointer `ptr` and wraps from N-1 to 0.
  - In fixed-priority mode, the lowest set index wins and `ptr` is ignored.
- `in_ready = load ? gnt : 0`.
  - `in_ready` depends on `in_valid`; producers must not make `in_valid` depend on `in_ready`.
- On a cycle with load=1 and any `in_valid`:
  - `out_data` and `out_sel` take the winner's values.
  - `out_valid` becomes 1.
  - In round-robin mode, `ptr` becomes `(winner+1) mod N`. When N is not a power of two, the wrap is explicit.
- On a cycle with load=1 and no `in_valid`: `out_valid` becomes 0. `out_data`, `out_sel` and `ptr` hold.
- While FULL and `out_ready`=0: all registers hold and `in_ready`=0.
- Simultaneous output pop and input push (FULL, `out_ready`=1, a request present): the new word is loaded in the same cycle, so throughput is one word per cycle.
- Fairness: in round-robin mode, with all channels continuously valid, each channel is granted exactly once per N transfers.
- A channel that drops `in_valid` before being granted loses nothing; no state is kept per channel.

## Timing
- Reset values: `out_valid`=0, `out_data`=0, `out_sel`=0, `ptr`=0.
- `in_ready` is all zeros in reset; after reset, `in_ready` follows the normal grant logic.
- Latency: word accepted at edge k appears on `out_data` and `out_valid` after edge k, i.e. 1 cycle.
- Reset asserted mid-operation:
  - Immediately, without waiting for a clock edge: `out_valid` clears and any held word is dropped.
  - `ptr` returns to 0.
- No combinational path from `in_data` to `out_data`.
- Combinational path `out_ready` → `in_ready` is by design.

## Structure
- Shared package `mux_pkg`:
  - Mode constants `MUX_MODE_RR`=0 and `MUX_MODE_FIXED`=1.
  - A function for the rotate-and-find-first one-hot grant.
- Sub-module `rr_arbiter`:
  - Parameter N; inputs `clk`, `rst`, `req[N]`, `advance`, `mode`; outputs `gnt[N]` and `gnt_idx[SELW]`.
  - It owns `ptr`, which it updates when `advance`=1.
- Top level: the data-select mux (one-hot AND-OR) plus the output register and handshake.

## Test plan
All cases use N=4, WIDTH=2 and round-robin mode unless stated; channel i drives data i.
- Reset check: assert `rst` with all `in_valid`=1 → while `rst`=1, `out_valid`=0, `out_data`=00, `out_sel`=0, `in_ready`=0000.
- Round-robin sweep:
  - Stimulus: `in_valid`=1111 with `out_ready`=1 held for 8 cycles.
  - Required: `out_sel` sequence 0,1,2,3,0,1,2,3; `out_data` equals `out_sel`; `out_valid` stays 1 from the first cycle after reset release.
- Sparse requests and wrap:
  - Stimulus: `in_valid`=1010 after a transfer from channel 3.
  - Required: channel 1 wins, then channel 3, then channel 1.
- Back-pressure:
  - Stimulus: FULL with `out_data`=10, then `out_ready`=0 for 3 cycles while `in_valid`=1111.
  - Required: `out_data` holds 10, `in_ready`=0000, and `ptr` does not move. After `out_ready` returns to 1, the next channel in round-robin order is loaded in the same cycle.
- Fixed-priority mode (`MODE`=1):
  - Stimulus: `in_valid`=1110 held.
  - Required: `out_sel`=1 every cycle; channels 2 and 3 starve.
- Drain and reset mid-transfer:
  - Stimulus: single word from channel 2, then `in_valid`=0 with `out_ready`=1.
  - Required: `out_valid` drops after 1 cycle. Asserting `rst` while FULL clears `out_valid` before the next edge.
